sigma_delta_adc: RTL and testbench
==================================

Name: sigma_delta_adc

Overview:
Digital half of a first-order delta-sigma ADC. It is the receive-side counterpart of the team's delta-sigma DAC.
- External parts: one comparator plus an RC integrator. The comparator compares the analog input against RC-filtered FbOut.
- The block synchronises the comparator bit, drives it back out as the 1-bit feedback, and decimates the bitstream by boxcar counting of ones.
- Each sample is presented in excess-2**(WIDTH-1) format, so ADCout feeds the DAC input directly for loopback. Output uses a valid/ready holding register.

Parameters:
WIDTH, 8, sample width in bits; the decimation window is 2**WIDTH clocks.

Ports:
Clk  in  1  system clock; all state changes on its rising edge
Reset  in  1  asynchronous, active-high reset
CompIn  in  1  comparator output, asynchronous to Clk
FbOut  out  1  registered feedback bit to the RC integrator (place in IOB)
En  in  1  conversion enable
ADCout  out  WIDTH  latest sample, excess-2**(WIDTH-1)
ADCvalid  out  1  ADCout holds an unconsumed sample
ADCready  in  1  consumer accepts ADCout when ADCvalid&&ADCready at an edge
Overrun  out  1  sticky: a completed sample replaced an unconsumed one
OvrClr  in  1  synchronous clear of Overrun

Behaviour:
- Reset values (asynchronous): sync1=0, sync2=0, FbOut=0, WinCnt=0, Acc=0, ADCout=0, ADCvalid=0, Overrun=0.
- Synchroniser: two flops, sync1<=CompIn then sync2<=sync1. Only sync2 is used internally.
- Feedback: FbOut<=sync2 every clock, regardless of En, so the analog loop always stays locked.
- Window counter WinCnt (WIDTH bits):
  - Increments by 1 each clock while En=1 and wraps from 2**WIDTH-1 to 0.
  - While En=0: WinCnt=0 and Acc=0, and no sample completes.
- Accumulator Acc (WIDTH bits): each clock, Acc<=Acc+sync2, except at terminal count.
- Terminal count (En=1, WinCnt=2**WIDTH-1):
  - Sum S=Acc+sync2, computed at WIDTH+1 bits.
  - Sample = min(S, 2**WIDTH-1), i.e. all-ones density saturates to full scale.
  - Acc<=0 at the same edge, so the next window starts empty.
  - The sample is written to ADCout at that edge, and ADCvalid<=1.
- Latency:
  - CompIn reaches sync2 two edges later.
  - The first sample after Reset release (with En=1) is registered at edge 2**WIDTH-1, counting the first edge as 0.
  - That first window includes the 2 reset-zero sync bits.
- Handshake:
  - If ADCvalid&&ADCready and no terminal count: ADCvalid<=0.
  - Terminal count together with ADCvalid&&ADCready: the new sample loads, ADCvalid stays 1, no overrun.
  - Terminal count with ADCvalid&&!ADCready: the newest sample overwrites, ADCvalid stays 1, Overrun<=1.
  - Overrun clears only on OvrClr=1. If OvrClr and a new overrun occur in the same cycle, set wins.
- En deassert mid-window: the partial window is discarded. A pending ADCout/ADCvalid is kept and can still be consumed.
- Reset mid-window: everything returns to reset values immediately; no partial sample is emitted.
- ADCout stays stable whenever ADCvalid=1 and no terminal count occurs.

Decomposition:
- Shared package holds only:
  - the excess-code midscale constant 2**(WIDTH-1);
  - the window-length constant 2**WIDTH.
- One natural sub-module, sd_bit_sync: the 2-flop synchroniser plus the FbOut register, so the IOB/timing constraints attach to a single instance.
- Counter, accumulator and output register stay in the top module.

Test Plan:
- Constant 1: CompIn=1, En=1, ADCready=1 from reset (WIDTH=8).
  -> First sample ADCout=254 at edge 255; every later window gives 255 (saturated); Overrun=0.
- Constant 0: CompIn=0.
  -> ADCout=0 every 256 clocks; FbOut=0 throughout.
- Alternating bits: CompIn toggles each clock (1,0,1,...), phase-aligned after warm-up.
  -> ADCout=128 (midscale) per window; FbOut toggles, 2 clocks behind CompIn.
- Overrun: hold ADCready=0 across two terminal counts with constant-1 input.
  -> ADCvalid=1, ADCout=255 (second sample), Overrun=1.
  -> Pulse OvrClr: Overrun=0. Pulse ADCready: ADCvalid=0 next edge.
- Simultaneous accept and completion: ADCready=1 exactly on the terminal-count edge while ADCvalid=1.
  -> ADCvalid stays 1, ADCout holds the new value, Overrun stays 0.
- Reset / En mid-window:
  - Assert Reset at WinCnt=100 -> all outputs 0 asynchronously; first new sample 256 edges after release.
  - Drop En at WinCnt=50 then raise it -> no sample until 256 edges after En rises, and prior ADCout is retained.

Source files
------------

// File: rtl/sigma_delta_adc_pkg.sv
// Shared constants for the delta-sigma ADC: default sample width, window length
// and the excess-code midscale used when looping ADC samples into the DAC.
package sigma_delta_adc_pkg;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int window_len(input int width);
    return 1 << width;
  endfunction

  // Excess-2**(W-1) zero point; a 50% bit density decimates to this code.
  function automatic int midscale(input int width);
    return 1 << (width - 1);
  endfunction

endpackage

// File: rtl/sigma_delta_adc_bit_sync.sv
// Comparator synchroniser plus the feedback flop; kept in one instance so the
// IOB and false-path constraints attach to a single place.
module sd_bit_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic CompIn,
  output logic sync_bit,
  output logic FbOut
);

  logic sync1;
  logic sync2;

  // Feedback runs every clock, independent of enable, so the analog loop stays locked.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      FbOut <= 1'b0;
    end else begin
      sync1 <= CompIn;
      sync2 <= sync1;
      FbOut <= sync2;
    end
  end

  assign sync_bit = sync2;

endmodule

// File: rtl/sigma_delta_adc.sv
// First-order delta-sigma ADC back end: boxcar decimation of the synchronised
// comparator bitstream into excess-code samples behind a valid/ready register.
module sigma_delta_adc
  import sigma_delta_adc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             CompIn,
  output logic             FbOut,
  input  logic             En,
  output logic [WIDTH-1:0] ADCout,
  output logic             ADCvalid,
  input  logic             ADCready,
  output logic             Overrun,
  input  logic             OvrClr
);

  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(window_len(WIDTH) - 1);

  logic             sync_bit;
  logic [WIDTH-1:0] win_cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sample;
  logic             term_cnt;
  logic             ovr_set;

  sd_bit_sync u_bit_sync (
    .Clk      (Clk),
    .Reset    (Reset),
    .CompIn   (CompIn),
    .sync_bit (sync_bit),
    .FbOut    (FbOut)
  );

  // A full window of ones counts 2**WIDTH, one past the code range, so clamp it.
  assign sum      = {1'b0, acc} + {{WIDTH{1'b0}}, sync_bit};
  assign sample   = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  assign term_cnt = En && (win_cnt == LAST_CNT);
  assign ovr_set  = term_cnt && ADCvalid && !ADCready;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      win_cnt  <= '0;
      acc      <= '0;
      ADCout   <= '0;
      ADCvalid <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      if (!En) begin
        win_cnt <= '0;
        acc     <= '0;
      end else begin
        win_cnt <= win_cnt + 1'b1;
        acc     <= term_cnt ? '0 : sum[WIDTH-1:0];
      end

      // A completing window always wins the holding register, accepted or not.
      if (term_cnt) begin
        ADCout   <= sample;
        ADCvalid <= 1'b1;
      end else if (ADCvalid && ADCready) begin
        ADCvalid <= 1'b0;
      end

      if (ovr_set) begin
        Overrun <= 1'b1;
      end else if (OvrClr) begin
        Overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sigma_delta_adc.sv
// Directed self-checking bench for sigma_delta_adc at WIDTH=8 (256-clock window).
module tb_sigma_delta_adc;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       CompIn;
  logic       FbOut;
  logic       En;
  logic [7:0] ADCout;
  logic       ADCvalid;
  logic       ADCready;
  logic       Overrun;
  logic       OvrClr;

  int checks = 0;
  int errors = 0;

  sigma_delta_adc #(.WIDTH(8)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .CompIn   (CompIn),
    .FbOut    (FbOut),
    .En       (En),
    .ADCout   (ADCout),
    .ADCvalid (ADCvalid),
    .ADCready (ADCready),
    .Overrun  (Overrun),
    .OvrClr   (OvrClr)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Holds reset with the given inputs, then releases on a falling edge; the next
  // rising edge is edge 0 of the first window.
  task automatic do_reset(input logic comp, input logic en, input logic rdy);
    Reset    = 1'b1;
    CompIn   = comp;
    En       = en;
    ADCready = rdy;
    OvrClr   = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0b expected=%0b", name, got, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; CompIn = 1'b1; En = 1'b1; ADCready = 1'b0; OvrClr = 1'b0;
    tick(3);
    check_bit("reset_fbout", FbOut, 1'b0);
    check_out("reset_adcout", ADCout, 8'd0);
    check_bit("reset_valid", ADCvalid, 1'b0);
    check_bit("reset_overrun", Overrun, 1'b0);
  endtask

  task automatic test_const_one;
    do_reset(1'b1, 1'b1, 1'b1);
    tick(255);
    check_bit("one_no_early_valid", ADCvalid, 1'b0);
    tick(1);
    check_bit("one_first_valid", ADCvalid, 1'b1);
    check_out("one_first_sample", ADCout, 8'd254);
    tick(1);
    check_bit("one_consumed", ADCvalid, 1'b0);
    tick(255);
    check_bit("one_second_valid", ADCvalid, 1'b1);
    check_out("one_saturated", ADCout, 8'd255);
    check_bit("one_overrun", Overrun, 1'b0);
    check_bit("one_fbout", FbOut, 1'b1);
  endtask

  task automatic test_const_zero;
    logic fb_seen = 1'b0;
    do_reset(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 512; k++) begin
      tick(1);
      if (FbOut !== 1'b0) fb_seen = 1'b1;
      if (k == 255) begin
        check_bit("zero_first_valid", ADCvalid, 1'b1);
        check_out("zero_first_sample", ADCout, 8'd0);
      end
    end
    check_bit("zero_second_valid", ADCvalid, 1'b1);
    check_out("zero_second_sample", ADCout, 8'd0);
    check_bit("zero_fbout_never_high", fb_seen, 1'b0);
  endtask

  task automatic test_alternating;
    logic hist [0:511];
    int   fb_bad = 0;
    do_reset(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 512; k++) begin
      hist[k] = CompIn;
      tick(1);
      if (k >= 2 && FbOut !== hist[k-2]) fb_bad++;
      CompIn = ~CompIn;
    end
    checks++;
    if (fb_bad != 0) begin
      errors++;
      $display("[TB] FAIL alt_fbout_delay got=%0d bad_edges expected=0", fb_bad);
    end
    check_bit("alt_valid", ADCvalid, 1'b1);
    check_out("alt_midscale", ADCout, 8'd128);
  endtask

  task automatic test_overrun;
    do_reset(1'b1, 1'b1, 1'b0);
    tick(256);
    check_out("ovr_first_sample", ADCout, 8'd254);
    check_bit("ovr_not_yet", Overrun, 1'b0);
    tick(256);
    check_bit("ovr_valid", ADCvalid, 1'b1);
    check_out("ovr_newest_sample", ADCout, 8'd255);
    check_bit("ovr_set", Overrun, 1'b1);
    OvrClr = 1'b1;
    tick(1);
    OvrClr = 1'b0;
    check_bit("ovr_cleared", Overrun, 1'b0);
    ADCready = 1'b1;
    tick(1);
    ADCready = 1'b0;
    check_bit("ovr_consumed", ADCvalid, 1'b0);
  endtask

  task automatic test_back_to_back;
    do_reset(1'b1, 1'b1, 1'b0);
    tick(256);
    check_bit("b2b_pending", ADCvalid, 1'b1);
    tick(255);
    ADCready = 1'b1;
    tick(1);
    check_bit("b2b_valid_kept", ADCvalid, 1'b1);
    check_out("b2b_new_sample", ADCout, 8'd255);
    check_bit("b2b_no_overrun", Overrun, 1'b0);
    tick(1);
    check_bit("b2b_drained", ADCvalid, 1'b0);
  endtask

  task automatic test_reset_mid;
    do_reset(1'b1, 1'b1, 1'b0);
    tick(356);
    check_bit("rmid_valid_before", ADCvalid, 1'b1);
    Reset = 1'b1;
    #1;
    check_out("rmid_adcout", ADCout, 8'd0);
    check_bit("rmid_valid", ADCvalid, 1'b0);
    check_bit("rmid_fbout", FbOut, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    tick(255);
    check_bit("rmid_no_early_sample", ADCvalid, 1'b0);
    tick(1);
    check_bit("rmid_new_valid", ADCvalid, 1'b1);
    check_out("rmid_new_sample", ADCout, 8'd254);
  endtask

  task automatic test_en_mid;
    do_reset(1'b1, 1'b1, 1'b0);
    tick(306);
    En = 1'b0;
    tick(10);
    check_bit("en_pending_kept", ADCvalid, 1'b1);
    check_out("en_sample_kept", ADCout, 8'd254);
    En = 1'b1;
    tick(255);
    check_out("en_no_early_sample", ADCout, 8'd254);
    check_bit("en_no_overrun_yet", Overrun, 1'b0);
    tick(1);
    check_out("en_full_window", ADCout, 8'd255);
    check_bit("en_overrun", Overrun, 1'b1);
  endtask

  initial begin
    test_reset();
    test_const_one();
    test_const_zero();
    test_alternating();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_en_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
